// File: rtl/sram_arbiter.sv
// sram_arbiter
// ------------
// Round-robin arbiter and access sequencer in front of the sram_top macro pair.
// Port A (instruction fetch) and port B (data/LSU) share the single RW port of
// sram_top. The arbiter issues at most one SRAM access per cycle. It returns a
// single-cycle response to the winner one cycle after acceptance.
//
// Optional feature (compile-time macro):
//   SRAM_ARB_ERR_EN - requests to the reserved region addr[AW-1:AW-2] == 2'b11
//                     are accepted but not issued to the SRAM. They get a
//                     response with err set and rdata 0. When the macro is
//                     undefined, every request is issued and the err outputs
//                     are tied low.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   a_valid_i / a_ready_o   port A request handshake (ready is combinational)
//   a_we_i, a_wmask_i       port A write enable and byte mask
//   a_addr_i, a_wdata_i     port A word address and write data
//   a_rvalid_o, a_rdata_o   port A response (one cycle after accept)
//   a_err_o                 port A error response
//   b_*                     port B, same set as port A
//   sram_web_o              sram_top web_i (active-low write enable)
//   sram_wmask_o            sram_top wmask_i
//   sram_addr_o             sram_top addr_i (addr[AW-1] selects the bank)
//   sram_wdata_o            sram_top din_i
//   sram_rdata_i            sram_top dout_o (valid the cycle after a read)
module sram_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          a_valid_i,
    output logic          a_ready_o,
    input  logic          a_we_i,
    input  logic [3:0]    a_wmask_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic          a_rvalid_o,
    output logic [DW-1:0] a_rdata_o,
    output logic          a_err_o,

    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic          b_we_i,
    input  logic [3:0]    b_wmask_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic          b_rvalid_o,
    output logic [DW-1:0] b_rdata_o,
    output logic          b_err_o,

    output logic          sram_web_o,
    output logic [3:0]    sram_wmask_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [DW-1:0] sram_wdata_o,
    input  logic [DW-1:0] sram_rdata_i
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] cnt);
        if (cnt >= HOLD_W'(MAX_HOLD)) begin
            return cnt;
        end
        return cnt + HOLD_W'(1);
    endfunction

    // Arbiter state and response tag, all registered at the end of the accept cycle
    port_e             last_port_p1;
    logic              last_vld_p1;
    logic              burst_p1;
    logic [HOLD_W-1:0] hold_cnt_p1;
    logic              vld_p1;
    port_e             rsp_port_p1;
    logic              rsp_we_p1;
    logic              rsp_err_p1;

    // Stage p0: arbitration and SRAM issue (combinational, accept cycle)
    logic          both_req;
    logic          keep;
    logic          grant;
    port_e         win;
    logic          sel_we;
    logic [3:0]    sel_wmask;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_err;
    logic          issue;

    // A port may keep the grant against a waiting competitor only if it was
    // already in a burst. A burst starts with an uncontested grant. A tie
    // resolved by round-robin does not open a burst, so two ports that are
    // both requesting all the time alternate.
    always_comb begin
        both_req = a_valid_i & b_valid_i;
        keep     = both_req & last_vld_p1 & burst_p1 &
                   (hold_cnt_p1 < HOLD_W'(MAX_HOLD));
        grant    = (a_valid_i | b_valid_i) & ~rst_i;
        win      = PORT_A;
        if (a_valid_i & ~b_valid_i) begin
            win = PORT_A;
        end else if (~a_valid_i & b_valid_i) begin
            win = PORT_B;
        end else if (both_req) begin
            if (keep) begin
                win = last_port_p1;
            end else begin
                win = (last_port_p1 == PORT_A) ? PORT_B : PORT_A;
            end
        end
    end

    always_comb begin
        if (win == PORT_B) begin
            sel_we    = b_we_i;
            sel_wmask = b_wmask_i;
            sel_addr  = b_addr_i;
            sel_wdata = b_wdata_i;
        end else begin
            sel_we    = a_we_i;
            sel_wmask = a_wmask_i;
            sel_addr  = a_addr_i;
            sel_wdata = a_wdata_i;
        end
    end

`ifdef SRAM_ARB_ERR_EN
    assign sel_err = (sel_addr[AW-1:AW-2] == 2'b11);
`else
    assign sel_err = 1'b0;
`endif

    // An accepted request in the reserved region is not issued. The SRAM port
    // then sees the same harmless read of address 0 as in an idle cycle.
    assign issue = grant & ~sel_err;

    assign a_ready_o    = grant & (win == PORT_A);
    assign b_ready_o    = grant & (win == PORT_B);
    assign sram_web_o   = ~(issue & sel_we);
    assign sram_wmask_o = issue ? sel_wmask : 4'b0000;
    assign sram_addr_o  = issue ? sel_addr  : '0;
    assign sram_wdata_o = issue ? sel_wdata : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_port_p1 <= PORT_B;
            last_vld_p1  <= 1'b0;
            burst_p1     <= 1'b0;
            hold_cnt_p1  <= '0;
            vld_p1       <= 1'b0;
            rsp_port_p1  <= PORT_A;
            rsp_we_p1    <= 1'b0;
            rsp_err_p1   <= 1'b0;
        end else begin
            if (grant) begin
                last_port_p1 <= win;
                last_vld_p1  <= 1'b1;
                burst_p1     <= ~both_req | keep;
                if (last_vld_p1 && (win == last_port_p1)) begin
                    hold_cnt_p1 <= hold_sat_inc(hold_cnt_p1);
                end else begin
                    hold_cnt_p1 <= '0;
                end
            end else begin
                last_vld_p1 <= 1'b0;
                burst_p1    <= 1'b0;
                hold_cnt_p1 <= '0;
            end
            vld_p1      <= grant;
            rsp_port_p1 <= win;
            rsp_we_p1   <= sel_we;
            rsp_err_p1  <= sel_err;
        end
    end

    // Stage p1: response to the winner of the previous cycle
    logic rsp_live;
    logic rsp_rd;

    // A reset that arrives while a response is pending suppresses it at once.
    assign rsp_live = vld_p1 & ~rst_i;
    assign rsp_rd   = ~rsp_we_p1 & ~rsp_err_p1;

    assign a_rvalid_o = rsp_live & (rsp_port_p1 == PORT_A);
    assign b_rvalid_o = rsp_live & (rsp_port_p1 == PORT_B);
    assign a_rdata_o  = (a_rvalid_o & rsp_rd) ? sram_rdata_i : '0;
    assign b_rdata_o  = (b_rvalid_o & rsp_rd) ? sram_rdata_i : '0;

`ifdef SRAM_ARB_ERR_EN
    assign a_err_o = a_rvalid_o & rsp_err_p1;
    assign b_err_o = b_rvalid_o & rsp_err_p1;
`else
    assign a_err_o = 1'b0;
    assign b_err_o = 1'b0;
`endif

endmodule
